regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Arbiter and sequencer sharing one bank of NREG 16-bit Registers between two requesters (req0 = control unit, req1 = debug/DMA port).
- Per-register E plus common FunSel/I driven by this block; register bank instantiated outside.
- Supports single-cycle FunSel ops and a two-cycle split 16-bit load over the byte path (write-low then write-high).

Parameters:
- NREG, 4, number of registers in the bank (1..16)
- IDX_W, 2, width of the register index, must satisfy 2**IDX_W >= NREG

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester command valid
- req_ready  out  2  per-requester ready; command transfers when valid&ready
- req0_idx / req1_idx  in  IDX_W each  target register index
- req0_cmd / req1_cmd  in  4 each  command: 0fff = direct FunSel fff; 1000 = SPLIT16; 1001..1111 reserved
- req0_data / req1_data  in  16 each  operand
- RegE  out  NREG  one-hot register enable
- RegFunSel  out  3  FunSel to all registers
- RegI  out  16  data to all registers
- done  out  2  one-cycle pulse per requester when its command finishes
- err  out  2  one-cycle pulse per requester for a rejected command

Behaviour:
- Reset: asynchronous, active-high. RegE=0, RegFunSel=000, RegI=0, done=0, err=0, req_ready=0, state=IDLE, rr_ptr=0. Takes effect immediately, mid-operation included.
- All outputs are registered.
- FSM states: IDLE, ISSUE, SPLIT_HI.
- IDLE:
  - req_ready is combinational. Only the arbitration winner sees ready=1.
  - Winner = the sole valid requester, or rr_ptr's requester if both are valid.
  - On accept: capture idx/cmd/data, set rr_ptr to the other requester, go to ISSUE.
- ISSUE (one cycle; the Register updates on the edge ending it):
  - Direct cmd: RegE = onehot(idx), RegFunSel = cmd[2:0], RegI = data. Raise done[winner], return to IDLE.
  - SPLIT16: RegE = onehot(idx), RegFunSel = 101, RegI = {8'h00, data[7:0]}. Go to SPLIT_HI.
  - Reserved cmd or idx >= NREG: RegE = 0, err[winner] = 1, return to IDLE. No register changes.
- SPLIT_HI: RegE = onehot(idx), RegFunSel = 110, RegI = {8'h00, data[15:8]}. Raise done[winner], return to IDLE.
- Outside ISSUE/SPLIT_HI: RegE = 0, RegFunSel = 000, RegI = 0.
- req_ready = 0 in ISSUE and SPLIT_HI.
- Throughput:
  - Direct: one accept every 2 cycles.
  - SPLIT16: one accept every 3 cycles.
- Latency: register updates 1 edge after accept for direct, 2 edges after accept for SPLIT16.
- Holding: a requester that keeps valid high while not granted must hold idx/cmd/data stable. Commands are never dropped.
- Reset during SPLIT_HI: low byte already written stays written, high byte is not written, no done pulse.

Optional Feature:
- Macro: REGFILE_CTRL_FIXED_PRIO_EN.
- Defined: requester 0 always wins simultaneous requests; rr_ptr is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Shared package regfile_ctrl_pkg holds:
  - FunSel constants: FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_CLR_WL=100, FS_WL=101, FS_WH=110, FS_SEXT=111
  - Command constant CMD_SPLIT16=4'b1000
  - FSM state enum
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with pointer; fixed-priority under the macro).

Test Plan:
- Reset, then req0 sends idx=2, cmd=0010, data=16'hBEEF -> next cycle RegE=0100, RegFunSel=010, RegI=BEEF, done[0] pulse; Register2 reads BEEF.
- req1 sends SPLIT16, idx=1, data=16'h1234 -> cycle1: RegE=0010, FunSel=101, RegI=0034. Cycle2: FunSel=110, RegI=0012, done[1]. Register1 with prior value 0 ends at 1234.
- Both valid every cycle with direct INC to idx 0 -> grants alternate 0,1,0,1. Register0 increments once per accepted command (+4 after 4 grants). With REGFILE_CTRL_FIXED_PRIO_EN, only req0 is granted.
- req0 cmd=1011 -> err[0] pulse, RegE=0, no done.
- req0 idx=3 with NREG=3 -> err[0] pulse, RegE=0, no done.
- Reset asserted mid SPLIT16 (in SPLIT_HI) -> RegE=0 immediately, state IDLE, target holds the low byte only, no done pulse.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file access controller: FunSel codes,
// the SPLIT16 command code and the sequencer state encoding.
package regfile_ctrl_pkg;

    localparam logic [2:0] FS_DEC    = 3'b000;
    localparam logic [2:0] FS_INC    = 3'b001;
    localparam logic [2:0] FS_LOAD   = 3'b010;
    localparam logic [2:0] FS_CLR    = 3'b011;
    localparam logic [2:0] FS_CLR_WL = 3'b100;
    localparam logic [2:0] FS_WL     = 3'b101;
    localparam logic [2:0] FS_WH     = 3'b110;
    localparam logic [2:0] FS_SEXT   = 3'b111;

    localparam logic [3:0] CMD_SPLIT16 = 4'b1000;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_SPLIT_HI = 2'd2;

endpackage

// File: rtl/regfile_access_ctrl_rr_arbiter2.sv
// Two-way arbiter. Round-robin by default; with REGFILE_CTRL_FIXED_PRIO_EN
// defined, requester 0 always wins and no pointer register exists.
module rr_arbiter2
    import regfile_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    output logic [1:0] grant
`ifndef REGFILE_CTRL_FIXED_PRIO_EN
   ,input  logic       clk,
    input  logic       rst,
    input  logic       advance
`endif
);

`ifdef REGFILE_CTRL_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (valid[0])
            grant = 2'b01;
        else if (valid[1])
            grant = 2'b10;
    end
`else
    logic rr_ptr;

    // On a tie the pointer picks the winner; otherwise the sole requester wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = rr_ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (advance)
            rr_ptr <= grant[0];
    end
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates two requesters onto one shared register bank and sequences
// direct FunSel ops and split 16-bit loads. Option: REGFILE_CTRL_FIXED_PRIO_EN.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [IDX_W-1:0] req0_idx,
    input  logic [IDX_W-1:0] req1_idx,
    input  logic [3:0]       req0_cmd,
    input  logic [3:0]       req1_cmd,
    input  logic [15:0]      req0_data,
    input  logic [15:0]      req1_data,
    output logic [NREG-1:0]  RegE,
    output logic [2:0]       RegFunSel,
    output logic [15:0]      RegI,
    output logic [1:0]       done,
    output logic [1:0]       err
);

    logic [1:0]       state;
    logic [1:0]       grant;
    logic             accept;
    logic             in_sel;
    logic [IDX_W-1:0] in_idx;
    logic [3:0]       in_cmd;
    logic [15:0]      in_data;
    logic             idx_bad;
    logic [NREG-1:0]  oh_in;
    logic [NREG-1:0]  oh_cap;
    logic [IDX_W-1:0] cap_idx;
    logic [7:0]       cap_hi;
    logic             cap_win;
    logic             cap_split;

`ifdef REGFILE_CTRL_FIXED_PRIO_EN
    rr_arbiter2 u_arb (
        .valid (req_valid),
        .grant (grant)
    );
`else
    rr_arbiter2 u_arb (
        .valid   (req_valid),
        .grant   (grant),
        .clk     (clk),
        .rst     (rst),
        .advance (accept)
    );
`endif

    assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign in_sel    = grant[1];
    assign in_idx    = in_sel ? req1_idx  : req0_idx;
    assign in_cmd    = in_sel ? req1_cmd  : req0_cmd;
    assign in_data   = in_sel ? req1_data : req0_data;
    assign idx_bad   = (32'(in_idx) >= 32'(NREG));

    always_comb begin
        oh_in  = '0;
        oh_cap = '0;
        for (int i = 0; i < NREG; i++) begin
            oh_in[i]  = (32'(in_idx)  == 32'(i));
            oh_cap[i] = (32'(cap_idx) == 32'(i));
        end
    end

    // Outputs are registered, so each state's bank drive is loaded on the
    // edge that enters that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            RegE      <= '0;
            RegFunSel <= FS_DEC;
            RegI      <= '0;
            done      <= 2'b00;
            err       <= 2'b00;
            cap_idx   <= '0;
            cap_hi    <= '0;
            cap_win   <= 1'b0;
            cap_split <= 1'b0;
        end else begin
            RegE      <= '0;
            RegFunSel <= FS_DEC;
            RegI      <= '0;
            done      <= 2'b00;
            err       <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_ISSUE;
                        cap_idx   <= in_idx;
                        cap_hi    <= in_data[15:8];
                        cap_win   <= in_sel;
                        cap_split <= 1'b0;
                        if (!in_cmd[3] && !idx_bad) begin
                            RegE         <= oh_in;
                            RegFunSel    <= in_cmd[2:0];
                            RegI         <= in_data;
                            done[in_sel] <= 1'b1;
                        end else if (in_cmd == CMD_SPLIT16 && !idx_bad) begin
                            RegE      <= oh_in;
                            RegFunSel <= FS_WL;
                            RegI      <= {8'h00, in_data[7:0]};
                            cap_split <= 1'b1;
                        end else begin
                            err[in_sel] <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cap_split) begin
                        state         <= ST_SPLIT_HI;
                        RegE          <= oh_cap;
                        RegFunSel     <= FS_WH;
                        RegI          <= {8'h00, cap_hi};
                        done[cap_win] <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized self-checking bench for regfile_access_ctrl with a
// transaction-level reference model and a behavioural register bank.
module tb_regfile_access_ctrl;

    localparam int NREG  = 3;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [IDX_W-1:0] req0_idx, req1_idx;
    logic [3:0]       req0_cmd, req1_cmd;
    logic [15:0]      req0_data, req1_data;
    logic [NREG-1:0]  RegE;
    logic [2:0]       RegFunSel;
    logic [15:0]      RegI;
    logic [1:0]       done, err;

    typedef struct {
        logic [NREG-1:0] e;
        logic [2:0]      fs;
        logic [15:0]     i;
        logic [1:0]      dn;
        logic [1:0]      er;
    } frame_t;

    typedef struct {
        int          idx;
        logic [3:0]  cmd;
        logic [15:0] data;
    } cmd_t;

    frame_t      exp_q[$];
    cmd_t        pend[2];
    bit          has_pend[2];
    int          busy;
    int          last_win;
    int          gen_mode;
    int          n_checks;
    int          n_pass;
    logic [15:0] model_reg[NREG];
    logic [15:0] bank[NREG];

    always #5 clk = ~clk;

    regfile_access_ctrl #(.NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_idx  (req0_idx),
        .req1_idx  (req1_idx),
        .req0_cmd  (req0_cmd),
        .req1_cmd  (req1_cmd),
        .req0_data (req0_data),
        .req1_data (req1_data),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .RegI      (RegI),
        .done      (done),
        .err       (err)
    );

    // Behavioural register semantics for each FunSel code.
    function automatic logic [15:0] apply_fs(input logic [15:0] v, input logic [2:0] fs,
                                             input logic [15:0] i);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return i;
            3'b011:  return 16'h0000;
            3'b100:  return {8'h00, i[7:0]};
            3'b101:  return {v[15:8], i[7:0]};
            3'b110:  return {i[7:0], v[7:0]};
            default: return {{8{i[7]}}, i[7:0]};
        endcase
    endfunction

    // External register bank driven only by the DUT's outputs.
    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++)
            if (RegE[k])
                bank[k] <= apply_fs(bank[k], RegFunSel, RegI);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic applyStimulus(input int r, input int idx, input logic [3:0] cmd,
                                 input logic [15:0] data);
        pend[r].idx  = idx;
        pend[r].cmd  = cmd;
        pend[r].data = data;
        has_pend[r]  = 1'b1;
    endtask

    // Reference model: what one accepted command must look like on the bank.
    task automatic accept_cmd(input int w);
        cmd_t   c;
        frame_t f;
        c = pend[w];
        has_pend[w] = 1'b0;
        last_win = w;
        f = '{default: '0};
        if (c.idx >= NREG || (c.cmd >= 4'd9)) begin
            f.er = 2'(1 << w);
            exp_q.push_back(f);
            busy = 1;
        end else if (c.cmd == 4'd8) begin
            f.e  = NREG'(1 << c.idx);
            f.fs = 3'd5;
            f.i  = {8'h00, c.data[7:0]};
            exp_q.push_back(f);
            f.fs = 3'd6;
            f.i  = {8'h00, c.data[15:8]};
            f.dn = 2'(1 << w);
            exp_q.push_back(f);
            model_reg[c.idx] = c.data;
            busy = 2;
        end else begin
            f.e  = NREG'(1 << c.idx);
            f.fs = c.cmd[2:0];
            f.i  = c.data;
            f.dn = 2'(1 << w);
            exp_q.push_back(f);
            model_reg[c.idx] = apply_fs(model_reg[c.idx], c.cmd[2:0], c.data);
            busy = 1;
        end
    endtask

    task automatic random_cmd(input int r);
        int          sel;
        logic [3:0]  cmd;
        sel = $urandom_range(0, 9);
        if (sel < 8)       cmd = 4'(sel);
        else if (sel == 8) cmd = 4'b1000;
        else               cmd = 4'(9 + $urandom_range(0, 6));
        applyStimulus(r, $urandom_range(0, 3), cmd, 16'($urandom));
    endtask

    task automatic step();
        frame_t     f;
        bit         idle;
        int         w;
        logic [1:0] exp_rdy;
        @(posedge clk);
        #1;
        f = '{default: '0};
        if (exp_q.size() > 0)
            f = exp_q.pop_front();
        checkOutput("RegE", 32'(RegE), 32'(f.e));
        checkOutput("RegFunSel", 32'(RegFunSel), 32'(f.fs));
        checkOutput("RegI", 32'(RegI), 32'(f.i));
        checkOutput("done", 32'(done), 32'(f.dn));
        checkOutput("err", 32'(err), 32'(f.er));
        idle = (busy == 0);
        if (!idle)
            busy--;
        for (int r = 0; r < 2; r++) begin
            if (!has_pend[r]) begin
                if (gen_mode == 1 && $urandom_range(0, 2) != 0)
                    random_cmd(r);
                else if (gen_mode == 2)
                    applyStimulus(r, 0, 4'b0001, 16'h0000);
            end
        end
        req_valid = {has_pend[1], has_pend[0]};
        req0_idx  = IDX_W'(pend[0].idx);
        req0_cmd  = pend[0].cmd;
        req0_data = pend[0].data;
        req1_idx  = IDX_W'(pend[1].idx);
        req1_cmd  = pend[1].cmd;
        req1_data = pend[1].data;
        #1;
        w = -1;
        if (idle) begin
            if (has_pend[0] && has_pend[1]) begin
`ifdef REGFILE_CTRL_FIXED_PRIO_EN
                w = 0;
`else
                w = 1 - last_win;
`endif
            end else if (has_pend[0]) begin
                w = 0;
            end else if (has_pend[1]) begin
                w = 1;
            end
        end
        exp_rdy = (w >= 0) ? 2'(1 << w) : 2'b00;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0)
            accept_cmd(w);
    endtask

    task automatic drain(input int n);
        gen_mode = 0;
        repeat (n) step();
    endtask

    task automatic compare_regs();
        for (int k = 0; k < NREG; k++)
            checkOutput($sformatf("reg%0d", k), 32'(bank[k]), 32'(model_reg[k]));
    endtask

    initial begin
        logic [15:0] pre;
        n_checks = 0;
        n_pass   = 0;
        busy     = 0;
        last_win = 1;
        gen_mode = 0;
        has_pend[0] = 1'b0;
        has_pend[1] = 1'b0;
        pend[0] = '{0, 4'h0, 16'h0};
        pend[1] = '{0, 4'h0, 16'h0};
        for (int k = 0; k < NREG; k++) begin
            bank[k]      = 16'h0000;
            model_reg[k] = 16'h0000;
        end
        rst = 1'b1;
        req_valid = 2'b11;
        req0_idx = '0; req1_idx = '0;
        req0_cmd = 4'h2; req1_cmd = 4'h2;
        req0_data = 16'h0; req1_data = 16'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst_RegE", 32'(RegE), 32'h0);
        checkOutput("rst_FunSel_I", {13'h0, RegFunSel, RegI}, 32'h0);
        checkOutput("rst_done_err", {28'h0, done, err}, 32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed cases: direct LOAD, SPLIT16, contention, reserved cmd, bad idx.
        applyStimulus(0, 2, 4'b0010, 16'hBEEF);
        drain(4);
        applyStimulus(1, 1, 4'b1000, 16'h1234);
        drain(4);
        gen_mode = 2;
        repeat (8) step();
        drain(6);
        applyStimulus(0, 0, 4'b1011, 16'h1111);
        drain(3);
        applyStimulus(0, 3, 4'b0010, 16'h2222);
        drain(3);
        compare_regs();
        checkOutput("reg2_beef", 32'(bank[2]), 32'h0000BEEF);

        // Reset while the high byte of a split load is on the bus.
        pre = model_reg[1];
        applyStimulus(1, 1, 4'b1000, 16'hA55A);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("midrst_RegE", 32'(RegE), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        exp_q.delete();
        busy = 0;
        last_win = 1;
        model_reg[1] = {pre[15:8], 8'h5A};
        #4 rst = 1'b0;
        drain(3);
        compare_regs();

        gen_mode = 1;
        repeat (600) step();
        drain(8);
        compare_regs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
